mealy_seq_detector: RTL

Parametrised Mealy-type serial sequence detector, the next generation of the team's fixed 4-state Mealy automata. It detects an arbitrary PAT_LEN-bit pattern on a 1-bit serial input, stepped by an enable strobe. Overlapping and non-overlapping modes are supported, state encoding is selectable, and the block keeps a saturating match counter. It sits between a serial-bit source, which drives a and en, and control or status logic that consumes y and match_cnt.

---
 rtl/mealy_seq_detector.sv | 91 +++++++++
 1 files changed

// File: rtl/mealy_seq_detector.sv
// mealy_seq_detector: KMP-based Mealy serial pattern detector with selectable state encoding and saturating match counter
module mealy_seq_detector #(
    parameter int                 PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1011,
    parameter int                 OVERLAP  = 1,
    parameter int                 ENCODING = 0,
    parameter int                 CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       a,
    output logic                       y,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_ovf,
    output logic [$clog2(PAT_LEN)-1:0] state_o
);
    localparam int SW = $clog2(PAT_LEN);
    localparam int RW = ENCODING == 1 ? PAT_LEN : SW;
    localparam int TW = 2 * (1 << SW) * SW;
    localparam logic [SW-1:0] LAST = SW'(PAT_LEN - 1);
    function automatic logic [TW-1:0] build_tbl();
        logic [TW-1:0] t;
        int best;
        logic ok, sb;
        t = '0;
        for (int k = 0; k < PAT_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int j = 1; j <= k + 1 && j < PAT_LEN; j++) begin
                    ok = 1'b1;
                    for (int i = 0; i < j; i++) begin
                        sb = (k + 1 - j + i == k) ? b[0] : PATTERN[PAT_LEN - 1 - (k + 1 - j + i)];
                        if (PATTERN[PAT_LEN - 1 - i] != sb) ok = 1'b0;
                    end
                    if (ok) best = j;
                end
                t[(k * 2 + b) * SW +: SW] = SW'(best);
            end
        end
        return t;
    endfunction
    localparam logic [TW-1:0] NXT = build_tbl();
    function automatic logic [RW-1:0] enc(input logic [SW-1:0] x);
        return ENCODING == 1 ? RW'(1) << x : ENCODING == 2 ? RW'(x ^ (x >> 1)) : RW'(x);
    endfunction
    logic [RW-1:0]    state_q, state_d;
    logic [SW-1:0]    idx, nidx;
    logic             vld, full;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    if (ENCODING == 1) begin : g_oh
        always_comb begin
            idx = '0;
            for (int i = 0; i < PAT_LEN; i++) if (state_q[i]) idx = SW'(i);
        end
        assign vld = $onehot(state_q);
    end else if (ENCODING == 2) begin : g_gray
        always_comb begin
            idx = '0;
            for (int i = 0; i < SW; i++) idx[i] = ^(state_q >> i);
        end
        assign vld = 32'(idx) < PAT_LEN;
    end else begin : g_bin
        assign idx = state_q;
        assign vld = 32'(idx) < PAT_LEN;
    end
    always_comb begin
        full    = vld && idx == LAST && a == PATTERN[0];
        nidx    = (full && OVERLAP == 0) ? '0 : NXT[int'({idx, a}) * SW +: SW];
        y       = en && full;
        state_o = vld ? idx : '0;
        state_d = (clr || !vld) ? enc('0) : en ? enc(nidx) : state_q;
        cnt_d   = clr ? '0 : (y && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        ovf_d   = clr ? 1'b0 : ovf_q || (y && cnt_q == '1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= enc('0);
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
    assign match_cnt = cnt_q;
    assign cnt_ovf   = ovf_q;
endmodule
